// File: rtl/mem_stage_ctrl.sv
// Memory-stage request controller: launches one pipeline load/store into mem_system,
// stalls the pipeline until Done (or watchdog abort). Optional macro: MEM_STAGE_ALIGN_CHK_EN.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic        dump_req,
    output logic        pipe_stall,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        err,
    output logic [15:0] acc_cnt,
    output logic [15:0] hit_cnt,
    output logic [15:0] mem_Addr,
    output logic [15:0] mem_DataIn,
    output logic        mem_Rd,
    output logic        mem_Wr,
    output logic        mem_createdump,
    input  logic [15:0] mem_DataOut,
    input  logic        mem_Done,
    input  logic        mem_Stall,
    input  logic        mem_CacheHit,
    input  logic        mem_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        is_rd_q, is_rd_d;
    logic [15:0] wdog_q, wdog_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] hit_q, hit_d;

    logic req_any;
    logic misalign;
    logic illegal;
    logic in_access;
    logic done_now;

    // Completion is defined by mem_Done alone; the cache's own stall is not needed.
    logic unused_mem_stall;
    assign unused_mem_stall = mem_Stall;

`ifdef MEM_STAGE_ALIGN_CHK_EN
    assign misalign = req_addr[0];
`else
    assign misalign = 1'b0;
`endif

    assign req_any   = req_rd | req_wr;
    assign illegal   = (req_rd & req_wr) | misalign;
    assign in_access = (state_q == ISSUE) || (state_q == WAIT);
    assign done_now  = in_access & mem_Done;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        is_rd_d = is_rd_q;
        wdog_d  = wdog_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        acc_d   = acc_q;
        hit_d   = hit_q;

        case (state_q)
            IDLE: begin
                if (req_any) begin
                    if (illegal) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        is_rd_d = req_rd;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                wdog_d  = 16'd0;
                state_d = mem_Done ? RESP : WAIT;
            end
            WAIT: begin
                if (mem_Done) begin
                    state_d = RESP;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                    if (wdog_d == TIMEOUT_W) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (in_access && mem_err) begin
            err_d = 1'b1;
        end

        if (done_now) begin
            if (is_rd_q) begin
                rdata_d = mem_DataOut;
            end
            acc_d = acc_q + 16'd1;
            if (mem_CacheHit) begin
                hit_d = hit_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 16'd0;
            wdata_q <= 16'd0;
            is_rd_q <= 1'b0;
            wdog_q  <= 16'd0;
            rdata_q <= 16'd0;
            err_q   <= 1'b0;
            acc_q   <= 16'd0;
            hit_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_rd_q <= is_rd_d;
            wdog_q  <= wdog_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            acc_q   <= acc_d;
            hit_q   <= hit_d;
        end
    end

    // Stall is combinational on the request so the pipeline freezes in the accept cycle.
    assign pipe_stall     = ~rst & (((state_q == IDLE) & req_any) | in_access);
    assign rsp_valid      = (state_q == RESP);
    assign rsp_rdata      = rdata_q;
    assign err            = err_q;
    assign acc_cnt        = acc_q;
    assign hit_cnt        = hit_q;
    assign mem_Addr       = addr_q;
    assign mem_DataIn     = wdata_q;
    assign mem_Rd         = (state_q == ISSUE) & is_rd_q;
    assign mem_Wr         = (state_q == ISSUE) & ~is_rd_q;
    assign mem_createdump = dump_req;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl; a second instance with TIMEOUT=8 covers the watchdog.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_rd, req_wr, dump_req;
    logic [15:0] req_addr, req_wdata;
    logic [15:0] mem_DataOut;
    logic        mem_Done, mem_Stall, mem_CacheHit, mem_err;

    logic        pipe_stall, rsp_valid, err, mem_Rd, mem_Wr, mem_createdump;
    logic [15:0] rsp_rdata, acc_cnt, hit_cnt, mem_Addr, mem_DataIn;

    logic        t_pipe_stall, t_rsp_valid, t_err, t_mem_Rd, t_mem_Wr, t_mem_createdump;
    logic [15:0] t_rsp_rdata, t_acc_cnt, t_hit_cnt, t_mem_Addr, t_mem_DataIn;

    int n_vec  = 0;
    int n_miss = 0;
    logic [15:0] exp_acc;
    logic [15:0] exp_hit;

    always #5 clk = ~clk;

    mem_stage_ctrl dut (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .dump_req(dump_req), .pipe_stall(pipe_stall),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .err(err), .acc_cnt(acc_cnt),
        .hit_cnt(hit_cnt), .mem_Addr(mem_Addr), .mem_DataIn(mem_DataIn), .mem_Rd(mem_Rd),
        .mem_Wr(mem_Wr), .mem_createdump(mem_createdump), .mem_DataOut(mem_DataOut),
        .mem_Done(mem_Done), .mem_Stall(mem_Stall), .mem_CacheHit(mem_CacheHit),
        .mem_err(mem_err)
    );

    mem_stage_ctrl #(.TIMEOUT(8)) dut8 (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .dump_req(dump_req), .pipe_stall(t_pipe_stall),
        .rsp_valid(t_rsp_valid), .rsp_rdata(t_rsp_rdata), .err(t_err), .acc_cnt(t_acc_cnt),
        .hit_cnt(t_hit_cnt), .mem_Addr(t_mem_Addr), .mem_DataIn(t_mem_DataIn),
        .mem_Rd(t_mem_Rd), .mem_Wr(t_mem_Wr), .mem_createdump(t_mem_createdump),
        .mem_DataOut(mem_DataOut), .mem_Done(mem_Done), .mem_Stall(mem_Stall),
        .mem_CacheHit(mem_CacheHit), .mem_err(mem_err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic done_pulse(input logic hit, input logic [15:0] data);
        mem_Done     = 1'b1;
        mem_CacheHit = hit;
        mem_DataOut  = data;
    endtask

    task automatic done_clear();
        mem_Done     = 1'b0;
        mem_CacheHit = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_rd = 1'b0; req_wr = 1'b0; dump_req = 1'b0;
        req_addr = 16'd0; req_wdata = 16'd0; mem_DataOut = 16'd0;
        mem_Done = 1'b0; mem_Stall = 1'b0; mem_CacheHit = 1'b0; mem_err = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_stall", {15'd0, pipe_stall}, 16'd0);
        chk("rst_valid", {15'd0, rsp_valid}, 16'd0);
        chk("rst_rdata", rsp_rdata, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        chk("rst_acc", acc_cnt, 16'd0);
        chk("rst_hit", hit_cnt, 16'd0);
        chk("rst_addr", mem_Addr, 16'd0);
        chk("rst_rdwr", {14'd0, mem_Rd, mem_Wr}, 16'd0);
        req_rd = 1'b1;
        #1 chk("rst_stall_req", {15'd0, pipe_stall}, 16'd0);
        req_rd = 1'b0;
        dump_req = 1'b1;
        #1 chk("dump", {15'd0, mem_createdump}, 16'd1);
        dump_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Load hit: Done at T+2, response at T+3
        req_rd = 1'b1; req_addr = 16'h0040;
        #1 chk("lh_stall_T", {15'd0, pipe_stall}, 16'd1);
        @(negedge clk);
        req_rd = 1'b0;
        chk("lh_rd_T1", {15'd0, mem_Rd}, 16'd1);
        chk("lh_addr_T1", mem_Addr, 16'h0040);
        @(negedge clk);
        chk("lh_rd_T2", {15'd0, mem_Rd}, 16'd0);
        done_pulse(1'b1, 16'h1234);
        @(negedge clk);
        done_clear();
        chk("lh_valid", {15'd0, rsp_valid}, 16'd1);
        chk("lh_rdata", rsp_rdata, 16'h1234);
        chk("lh_acc", acc_cnt, 16'd1);
        chk("lh_hit", hit_cnt, 16'd1);
        chk("lh_stall_resp", {15'd0, pipe_stall}, 16'd0);
        @(negedge clk);
        chk("lh_valid_off", {15'd0, rsp_valid}, 16'd0);

        // Timeout on the TIMEOUT=8 instance: response at T+10
        req_rd = 1'b1; req_addr = 16'h0080;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) req_rd = 1'b0;
            chk($sformatf("to_valid_T%0d", k), {15'd0, t_rsp_valid}, 16'd0);
        end
        chk("to_err_T9", {15'd0, t_err}, 16'd0);
        @(negedge clk);
        chk("to_valid_T10", {15'd0, t_rsp_valid}, 16'd1);
        chk("to_err", {15'd0, t_err}, 16'd1);
        chk("to_rdata", t_rsp_rdata, 16'h1234);
        chk("to_acc", t_acc_cnt, 16'd1);
        chk("to_hit", t_hit_cnt, 16'd1);
        chk("to_main_wait", {15'd0, rsp_valid}, 16'd0);
        done_pulse(1'b0, 16'h5555);
        @(negedge clk);
        done_clear();
        chk("lm_valid", {15'd0, rsp_valid}, 16'd1);
        chk("lm_rdata", rsp_rdata, 16'h5555);
        chk("lm_acc", acc_cnt, 16'd2);
        chk("lm_hit", hit_cnt, 16'd1);
        chk("lm_err", {15'd0, err}, 16'd0);
        @(negedge clk);

        // Store miss: Done at T+12
        req_wr = 1'b1; req_addr = 16'h0100; req_wdata = 16'hBEEF;
        #1 chk("sm_stall_T", {15'd0, pipe_stall}, 16'd1);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) req_wr = 1'b0;
            chk($sformatf("sm_wr_T%0d", k), {15'd0, mem_Wr}, (k == 1) ? 16'd1 : 16'd0);
            chk($sformatf("sm_addr_T%0d", k), mem_Addr, 16'h0100);
            chk($sformatf("sm_data_T%0d", k), mem_DataIn, 16'hBEEF);
            chk($sformatf("sm_stall_T%0d", k), {15'd0, pipe_stall}, 16'd1);
            if (k == 12) done_pulse(1'b0, 16'h0000);
        end
        @(negedge clk);
        done_clear();
        chk("sm_valid", {15'd0, rsp_valid}, 16'd1);
        chk("sm_rdata", rsp_rdata, 16'h5555);
        chk("sm_acc", acc_cnt, 16'd3);
        chk("sm_hit", hit_cnt, 16'd1);
        @(negedge clk);

        // Odd address 0x0003
        req_rd = 1'b1; req_addr = 16'h0003;
        @(negedge clk);
        req_rd = 1'b0;
`ifdef MEM_STAGE_ALIGN_CHK_EN
        chk("mis_valid", {15'd0, rsp_valid}, 16'd1);
        chk("mis_err", {15'd0, err}, 16'd1);
        chk("mis_rd", {15'd0, mem_Rd}, 16'd0);
        @(negedge clk);
        chk("mis_acc", acc_cnt, 16'd3);
        exp_acc = 16'd3;
`else
        chk("mis_rd", {15'd0, mem_Rd}, 16'd1);
        chk("mis_addr", mem_Addr, 16'h0003);
        done_pulse(1'b1, 16'hA5A5);
        @(negedge clk);
        done_clear();
        chk("mis_valid", {15'd0, rsp_valid}, 16'd1);
        chk("mis_rdata", rsp_rdata, 16'hA5A5);
        chk("mis_acc", acc_cnt, 16'd4);
        chk("mis_hit", hit_cnt, 16'd2);
        chk("mis_err", {15'd0, err}, 16'd0);
        exp_acc = 16'd4;
`endif
        @(negedge clk);

        // Illegal: both read and write
        req_rd = 1'b1; req_wr = 1'b1; req_addr = 16'h0010;
        #1 chk("ill_stall_T", {15'd0, pipe_stall}, 16'd1);
        @(negedge clk);
        req_rd = 1'b0; req_wr = 1'b0;
        chk("ill_rdwr", {14'd0, mem_Rd, mem_Wr}, 16'd0);
        chk("ill_valid", {15'd0, rsp_valid}, 16'd1);
        chk("ill_err", {15'd0, err}, 16'd1);
        chk("ill_acc", acc_cnt, exp_acc);
        @(negedge clk);

        // Reset clears the sticky error
        rst = 1'b1;
        #1 chk("rst2_err", {15'd0, err}, 16'd0);
        chk("rst2_acc", acc_cnt, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Minimum-latency load to populate state before the mid-access reset
        req_rd = 1'b1; req_addr = 16'h0042;
        @(negedge clk);
        req_rd = 1'b0;
        done_pulse(1'b0, 16'h0BAD);
        @(negedge clk);
        done_clear();
        chk("ml_valid", {15'd0, rsp_valid}, 16'd1);
        chk("ml_rdata", rsp_rdata, 16'h0BAD);
        chk("ml_acc", acc_cnt, 16'd1);
        @(negedge clk);

        // Pending load with mem_err, then reset at T+4
        req_rd = 1'b1; req_addr = 16'h0200;
        @(negedge clk);
        req_rd = 1'b0;
        @(negedge clk);
        mem_err = 1'b1;
        @(negedge clk);
        mem_err = 1'b0;
        chk("pl_err", {15'd0, err}, 16'd1);
        @(negedge clk);
        chk("pl_stall_T4", {15'd0, pipe_stall}, 16'd1);
        rst = 1'b1;
        #1;
        chk("mr_stall", {15'd0, pipe_stall}, 16'd0);
        chk("mr_rd", {15'd0, mem_Rd}, 16'd0);
        chk("mr_err", {15'd0, err}, 16'd0);
        chk("mr_acc", acc_cnt, 16'd0);
        chk("mr_rdata", rsp_rdata, 16'd0);
        chk("mr_addr", mem_Addr, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        req_rd = 1'b1; req_addr = 16'h0044;
        @(negedge clk);
        req_rd = 1'b0;
        chk("ar_addr", mem_Addr, 16'h0044);
        done_pulse(1'b1, 16'h7E57);
        @(negedge clk);
        done_clear();
        chk("ar_valid", {15'd0, rsp_valid}, 16'd1);
        chk("ar_rdata", rsp_rdata, 16'h7E57);
        chk("ar_acc", acc_cnt, 16'd1);
        chk("ar_hit", hit_cnt, 16'd1);
        @(negedge clk);

        // Counter wrap from 16'hFFFF
        force dut.acc_q = 16'hFFFF;
        force dut.hit_q = 16'hFFFF;
        @(negedge clk);
        release dut.acc_q;
        release dut.hit_q;
        #1 chk("wr_pre_acc", acc_cnt, 16'hFFFF);
        exp_hit = 16'd0;
        req_rd = 1'b1; req_addr = 16'h0046;
        @(negedge clk);
        req_rd = 1'b0;
        done_pulse(1'b1, 16'h1111);
        @(negedge clk);
        done_clear();
        chk("wr_valid", {15'd0, rsp_valid}, 16'd1);
        chk("wr_acc", acc_cnt, 16'd0);
        chk("wr_hit", hit_cnt, exp_hit);
        chk("wr_rdata", rsp_rdata, 16'h1111);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage request controller between the pipeline memory stage and `mem_system`. It accepts one load/store from the pipeline and launches it into `mem_system` with a one-cycle `Rd`/`Wr` pulse. It holds `Addr`/`DataIn` stable until `Done`, stalls the pipeline for the access duration and returns read data with a one-cycle valid pulse. It also maintains hit/access counters, a sticky error flag and a watchdog against a hung cache.

## Interface
- `TIMEOUT`, default 64: max cycles in WAIT without `mem_Done` before abort; legal range 2..65535.
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_rd`  in  1  pipeline load request
- `req_wr`  in  1  pipeline store request
- `req_addr`  in  16  byte address
- `req_wdata`  in  16  store data
- `dump_req`  in  1  dump request, passed combinationally to `mem_createdump`
- `pipe_stall`  out  1  stall pipeline; request inputs held stable by pipeline while high
- `rsp_valid`  out  1  one-cycle pulse: access complete
- `rsp_rdata`  out  16  last load data, held until next completed load
- `err`  out  1  sticky error flag
- `acc_cnt`  out  16  completed memory accesses
- `hit_cnt`  out  16  completed accesses with `mem_CacheHit` high
- `mem_Addr`, `mem_DataIn`  out  16 each  to `mem_system` `Addr`/`DataIn`
- `mem_Rd`, `mem_Wr`, `mem_createdump`  out  1 each  to `mem_system`
- `mem_DataOut`  in  16  from `mem_system`
- `mem_Done`, `mem_Stall`, `mem_CacheHit`, `mem_err`  in  1 each  from `mem_system`

## Operation
- States: IDLE, ISSUE, WAIT, RESP; 2-bit state register; reset → IDLE.
- IDLE: request present when `req_rd|req_wr`.
  - Legal request: register addr, wdata and type into `mem_Addr`/`mem_DataIn`; → ISSUE.
  - Illegal request (`req_rd&req_wr`, or misaligned per Configuration): set `err`; no memory access; → RESP.
- ISSUE: `mem_Rd` or `mem_Wr` high for exactly this cycle. → RESP if `mem_Done`, else → WAIT; clear watchdog counter.
- WAIT: `mem_Rd`/`mem_Wr` low; `mem_Addr`/`mem_DataIn` unchanged.
  - `mem_Done` → RESP.
  - Otherwise the watchdog increments. When it reaches `TIMEOUT`, set `err` and → RESP; `rsp_rdata` is not updated.
- On the `mem_Done` cycle (ISSUE or WAIT):
  - Load: capture `mem_DataOut` into `rsp_rdata`.
  - `acc_cnt`+1; `hit_cnt`+1 if `mem_CacheHit`.
  - `mem_err` high on this cycle or any ISSUE/WAIT cycle sets `err`.
- RESP: `rsp_valid`=1, `pipe_stall`=0; → IDLE unconditionally. Requests are not sampled in RESP.
- `pipe_stall` = (IDLE & (`req_rd|req_wr`)) | ISSUE | WAIT; forced 0 while `rst`.
- Counters are 16-bit unsigned; wrap 16'hFFFF → 0. Illegal and timed-out requests are not counted.
- `err` clears only on `rst`.
- `mem_Stall` is informational only; completion is defined solely by `mem_Done`.

## Timing
- Reset values: state IDLE; `rsp_valid` 0, `rsp_rdata` 0, `err` 0, `acc_cnt` 0, `hit_cnt` 0, `mem_Addr` 0, `mem_DataIn` 0, `mem_Rd` 0, `mem_Wr` 0, `pipe_stall` 0. `mem_createdump` follows `dump_req`.
- Accept at cycle T (IDLE) → ISSUE at T+1.
- `mem_Done` at cycle D ≥ T+1 → `rsp_valid` at D+1. Minimum request-to-response latency is 2 cycles.
- Back-to-back: the next request is accepted earliest at D+2, giving a 1-cycle bubble.
- Illegal request at T → `rsp_valid` at T+1.
- Timeout: `rsp_valid` at T+2+`TIMEOUT`.
- Reset asserted mid-access: all outputs reach reset values immediately (asynchronous). The in-flight access is abandoned; `mem_system` is reset by the same `rst`.

## Configuration
- `MEM_STAGE_ALIGN_CHK_EN` defined: a request with `req_addr[0]`=1 is illegal. It sets `err`, produces no memory access and completes in RESP at T+1.
- Not defined: no alignment check; `req_addr` is forwarded unmodified, bit 0 included.

## Test plan
- Load hit: preload 0x0040=0x1234; `req_rd`, addr 0x0040; stub `mem_Done`+`mem_CacheHit` at T+2 → `rsp_valid` at T+3, `rsp_rdata`=0x1234, `acc_cnt`=1, `hit_cnt`=1.
- Store miss: `req_wr`, addr 0x0100, data 0xBEEF, `mem_Done` at T+12 without hit → `mem_Wr` high only at T+1; `mem_Addr`=0x0100 and `mem_DataIn`=0xBEEF held T+1..T+12; `pipe_stall` high T..T+12; `hit_cnt` unchanged.
- Timeout: `TIMEOUT`=8, `mem_Done` never asserted → `err`=1 and `rsp_valid` at T+10; `rsp_rdata` and counters unchanged.
- Illegal request: `req_rd`=`req_wr`=1 → no `mem_Rd`/`mem_Wr`, `rsp_valid` at T+1, `err`=1. With `MEM_STAGE_ALIGN_CHK_EN`, addr 0x0003 gives the same response; without the macro, 0x0003 reaches `mem_Addr`.
- Reset mid-WAIT: assert `rst` at T+4 of a pending load → `pipe_stall`, `mem_Rd`, `err`, counters and `rsp_rdata` 0 in the same cycle. After release, a new load completes normally.
- Counter wrap: preset 65535 completed hits → next hit gives `acc_cnt`=0, `hit_cnt`=0.
